instr_queue: RTL and testbench

Multi-lane in-order FIFO between the decode (ID) and issue/rename (IR) stages. It buffers up to INSTRUCTION_QUEUE_NUM_ENTRIES decoded instructions of type id_ir_stage_t. Each cycle it accepts up to NUM_SCALAR_INSTR instructions and presents up to NUM_SCALAR_INSTR head entries to the issue logic. The issue logic pops them with per-lane read strobes.

---
 rtl/drac_pkg.sv | 26 ++
 rtl/instr_queue.sv | 95 +++++++++
 tb/tb_instr_queue.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/drac_pkg.sv
// Shared decode/issue types and sizing for the front-end pipeline.
//   NUM_SCALAR_INSTR              : lanes per cycle through the ID->IR boundary
//   INSTRUCTION_QUEUE_NUM_ENTRIES : depth of the ID->IR instruction queue (power of two)
//   iq_ptr_t / iq_num_t           : queue pointer and occupancy count types
//   id_ir_stage_t                 : one decoded instruction handed from ID to IR
package drac_pkg;

    localparam int NUM_SCALAR_INSTR              = 2;
    localparam int INSTRUCTION_QUEUE_NUM_ENTRIES = 16;

    typedef logic [$clog2(INSTRUCTION_QUEUE_NUM_ENTRIES)-1:0] iq_ptr_t;
    typedef logic [$clog2(INSTRUCTION_QUEUE_NUM_ENTRIES):0]   iq_num_t;

    typedef struct packed {
        logic        valid;
        logic [39:0] pc;
        logic [31:0] inst;
    } instr_t;

    typedef struct packed {
        instr_t      instr;
        logic [3:0]  ex_cause;
        logic        ex_valid;
    } id_ir_stage_t;

endpackage

// File: rtl/instr_queue.sv
// In-order multi-lane instruction queue between decode (ID) and issue/rename (IR).
// Accepts up to NUM_SCALAR_INSTR instructions per cycle and presents up to
// NUM_SCALAR_INSTR head entries, popped by per-lane read strobes.
//   clk_i           : clock, all state updates on rising edge
//   rst_i           : synchronous active-high reset (priority over flush_i)
//   instruction_S_i : lanes to enqueue; valid lanes form a prefix from lane 0
//   flush_i         : discard all contents, overrides push/pop
//   read_head_S_i   : lane k pops entry head+k; strobes form a prefix from lane 0
//   instruction_S_o : entry at head+k, valid forced low when k >= num
//   full_o          : fewer than NUM_SCALAR_INSTR free slots (registered num only)
//   empty_o         : queue holds no entries (registered num only)
module instr_queue
    import drac_pkg::*;
(
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  id_ir_stage_t [NUM_SCALAR_INSTR-1:0]   instruction_S_i,
    input  logic                                  flush_i,
    input  logic         [NUM_SCALAR_INSTR-1:0]   read_head_S_i,
    output id_ir_stage_t [NUM_SCALAR_INSTR-1:0]   instruction_S_o,
    output logic                                  full_o,
    output logic                                  empty_o
);

    localparam int DEPTH = INSTRUCTION_QUEUE_NUM_ENTRIES;
    localparam int N     = NUM_SCALAR_INSTR;

    id_ir_stage_t mem [DEPTH];
    iq_ptr_t      head;
    iq_ptr_t      tail;
    iq_num_t      num;

    iq_num_t      push_cnt;
    iq_num_t      pop_cnt;
    logic         push_run;
    logic         pop_run;

    // Full/empty depend only on registered num, so a same-cycle pop can never
    // open room for a push that full_o already refused.
    assign full_o  = (num > iq_num_t'(DEPTH - N));
    assign empty_o = (num == '0);

    // Only the leading run of valid lanes / strobes counts; pops beyond the
    // current occupancy are ignored. A full queue drops the whole push.
    always_comb begin
        push_cnt = '0;
        pop_cnt  = '0;
        push_run = 1'b1;
        pop_run  = 1'b1;
        for (int k = 0; k < N; k++) begin
            push_run = push_run & instruction_S_i[k].instr.valid;
            if (push_run) begin
                push_cnt = push_cnt + iq_num_t'(1);
            end
            pop_run = pop_run & read_head_S_i[k] & (iq_num_t'(k) < num);
            if (pop_run) begin
                pop_cnt = pop_cnt + iq_num_t'(1);
            end
        end
        if (full_o) begin
            push_cnt = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            head <= '0;
            tail <= '0;
            num  <= '0;
        end else begin
            // Pointer arithmetic wraps modulo DEPTH, so a push spanning the end
            // of the array lands at index 0 in the same cycle.
            for (int k = 0; k < N; k++) begin
                if (iq_num_t'(k) < push_cnt) begin
                    mem[tail + iq_ptr_t'(k)] <= instruction_S_i[k];
                end
            end
            tail <= tail + iq_ptr_t'(push_cnt);
            head <= head + iq_ptr_t'(pop_cnt);
            num  <= num + push_cnt - pop_cnt;
        end
    end

    // Read side is combinational from registered head/num; there is no bypass
    // from the write port, so a push is visible one cycle later at the earliest.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            instruction_S_o[k] = mem[head + iq_ptr_t'(k)];
            if (iq_num_t'(k) >= num) begin
                instruction_S_o[k].instr.valid = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_queue.sv
// Scoreboard bench for instr_queue: directed phases (reset, fill, overflow,
// drain, wrap with concurrent push/pop, flush, mid-run reset) followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_instr_queue;
    import drac_pkg::*;

    localparam int N     = NUM_SCALAR_INSTR;
    localparam int DEPTH = INSTRUCTION_QUEUE_NUM_ENTRIES;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      flush;
    id_ir_stage_t [N-1:0]      din;
    id_ir_stage_t [N-1:0]      dout;
    logic         [N-1:0]      rd;
    logic                      full;
    logic                      empty;

    always #5 clk = ~clk;

    instr_queue dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .instruction_S_i (din),
        .flush_i         (flush),
        .read_head_S_i   (rd),
        .instruction_S_o (dout),
        .full_o          (full),
        .empty_o         (empty)
    );

    // Reference model: expected contents in order plus plain-integer bookkeeping.
    id_ir_stage_t exp_q[$];
    int           model_num;
    int           model_head;
    int           model_tail;
    bit           mon_en;
    int           n_checks;
    int           n_pass;
    int unsigned  tag;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: compare what the DUT presents, then retire the popped entries.
    always @(negedge clk) begin
        if (mon_en) begin
            int npop;
            bit run;
            chk("num",   128'(dut.num),  128'(model_num));
            chk("head",  128'(dut.head), 128'(model_head));
            chk("tail",  128'(dut.tail), 128'(model_tail));
            chk("empty", 128'(empty),    128'(model_num == 0));
            chk("full",  128'(full),     128'(model_num > DEPTH - N));
            for (int k = 0; k < N; k++) begin
                chk("out_valid", 128'(dout[k].instr.valid), 128'(k < model_num));
                if (k < model_num) begin
                    if (k < exp_q.size()) begin
                        chk("out_entry", 128'(dout[k]), 128'(exp_q[k]));
                    end else begin
                        n_checks++;
                        $display("FAIL scoreboard: lane %0d expected entry missing", k);
                    end
                end
            end
            npop = 0;
            run  = 1'b1;
            for (int k = 0; k < N; k++) begin
                run = run & rd[k] & (k < model_num);
                if (run) npop++;
            end
            repeat (npop) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
        end
    end

    // Drive one cycle of stimulus, then advance the model at the clock edge.
    task automatic step(input int npush, input int npop, input bit fl, input bit rs);
        int pops;
        int pushes;
        for (int k = 0; k < N; k++) begin
            din[k] = '0;
            if (k < npush) begin
                din[k].instr.valid = 1'b1;
                din[k].instr.pc    = {8'h00, tag};
                din[k].instr.inst  = $urandom;
                din[k].ex_cause    = 4'($urandom_range(0, 15));
                tag++;
            end
            rd[k] = (k < npop);
        end
        flush = fl;
        rst   = rs;
        @(posedge clk);
        if (rs || fl) begin
            exp_q.delete();
            model_num  = 0;
            model_head = 0;
            model_tail = 0;
        end else begin
            pops   = (npop < model_num) ? npop : model_num;
            pushes = (model_num > DEPTH - N) ? 0 : npush;
            for (int k = 0; k < pushes; k++) exp_q.push_back(din[k]);
            model_head = (model_head + pops) % DEPTH;
            model_tail = (model_tail + pushes) % DEPTH;
            model_num  = model_num + pushes - pops;
        end
        #1;
    endtask

    initial begin
        int np;
        int nr;
        bit fl;
        bit rs;
        mon_en   = 1'b0;
        n_checks = 0;
        n_pass   = 0;
        tag      = 32'h100;
        rst      = 1'b1;
        flush    = 1'b0;
        rd       = '0;
        din      = '0;
        model_num  = 0;
        model_head = 0;
        model_tail = 0;

        step(0, 0, 1'b0, 1'b1);
        mon_en = 1'b1;
        step(0, 0, 1'b0, 1'b0);

        repeat (8) step(2, 0, 1'b0, 1'b0);   // fill to 16
        repeat (2) step(2, 0, 1'b0, 1'b0);   // overflow, dropped
        repeat (8) step(0, 2, 1'b0, 1'b0);   // drain in order
        repeat (2) step(0, 2, 1'b0, 1'b0);   // strobes on empty queue

        repeat (7) begin                      // walk pointers to 14
            step(2, 0, 1'b0, 1'b0);
            step(0, 2, 1'b0, 1'b0);
        end
        step(2, 0, 1'b0, 1'b0);               // push across the wrap
        step(2, 1, 1'b0, 1'b0);               // concurrent push 2 / pop 1
        repeat (3) step(0, 2, 1'b0, 1'b0);    // order across the wrap

        repeat (3) step(2, 0, 1'b0, 1'b0);    // num = 6
        step(2, 1, 1'b1, 1'b0);               // flush beats push and pop
        step(0, 0, 1'b0, 1'b0);

        repeat (3) step(2, 0, 1'b0, 1'b0);
        step(1, 1, 1'b0, 1'b1);               // reset mid-operation
        step(0, 0, 1'b0, 1'b0);

        repeat (400) begin
            np = $urandom_range(0, N);
            nr = $urandom_range(0, N);
            fl = ($urandom_range(0, 99) == 0);
            rs = ($urandom_range(0, 149) == 0);
            step(np, nr, fl, rs);
        end

        step(0, 0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
